serial_and_sequencer: RTL and testbench

//   Bit-serial operand sequencer that sits directly upstream and downstream of the

---
 rtl/serial_and_sequencer.sv | 92 +++++++++
 tb/tb_serial_and_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_and_sequencer.sv
// Bit-serial sequencer around an external 1-bit AND gate: shifts two operands out LSB first
// and collects the gate output into a WIDTH-bit result with a done pulse and zero flag.
module serial_and_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             zero_q, zero_d;

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                result_d = {gate_c, result_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                if (cnt_q == CntLast) begin
                    // Last bit lands this edge; zero is published with the final result.
                    cnt_d   = '0;
                    zero_d  = (result_d == '0);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
        end
    end

    assign gate_a = (state_q == StShift) & a_sr_q[0];
    assign gate_b = (state_q == StShift) & b_sr_q[0];
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_and_sequencer.sv
// Directed plus randomized bench for serial_and_sequencer with WIDTH=8 and an AND gate model.
module tb_serial_and_sequencer;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             gate_a, gate_b, gate_c;
    logic             busy, done, zero;
    logic [WIDTH-1:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] exp_result = '0;
    logic             exp_zero = 1'b0;

    always #5 clk = ~clk;

    assign gate_c = gate_a & gate_b;

    serial_and_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .gate_a (gate_a),
        .gate_b (gate_b),
        .gate_c (gate_c),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // One operation; inject_at >= 0 pulses a competing start in that SHIFT cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int inject_at, input string tag);
        logic [WIDTH-1:0] want;
        want = a & b;
        wait_idle();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_clr"}, 32'(result), 32'd0);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i == inject_at) begin
                start = 1'b1;
                a_in  = 8'hF0;
                b_in  = 8'hF0;
            end
            if (i == inject_at + 1) start = 1'b0;
            check({tag, "_ga"}, 32'(gate_a), 32'((a >> i) & 1));
            check({tag, "_gb"}, 32'(gate_b), 32'((b >> i) & 1));
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_zhold"}, 32'(zero), 32'(exp_zero));
            step();
        end
        start      = 1'b0;
        exp_result = want;
        exp_zero   = (want == 0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_res"}, 32'(result), 32'(exp_result));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        step();
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int last_rise;
        int low_run;
        logic prev_busy;

        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_ga", 32'(gate_a), 32'd0);
        check("rst_gb", 32'(gate_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op(8'hF0, 8'h3C, -1, "t1");
        run_op(8'hAA, 8'h55, -1, "t2");

        // Held start: accepts must recur every WIDTH+2 cycles with one idle cycle between.
        wait_idle();
        a_in      = 8'hFF;
        b_in      = 8'hFF;
        start     = 1'b1;
        last_rise = -1;
        low_run   = 0;
        prev_busy = busy;
        for (int c = 0; c < 35; c++) begin
            step();
            if (busy && !prev_busy) begin
                if (last_rise >= 0) begin
                    check("t3_period", 32'(c - last_rise), 32'(WIDTH + 2));
                    check("t3_gap", 32'(low_run), 32'd1);
                end
                last_rise = c;
            end
            if (busy) low_run = 0;
            else low_run++;
            if (done) begin
                check("t3_res", 32'(result), 32'hFF);
                check("t3_zero", 32'(zero), 32'd0);
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("t3_accepts", 32'(last_rise >= 30), 32'd1);
        exp_result = 8'hFF;
        exp_zero   = 1'b0;

        run_op(8'h0F, 8'h0F, 3, "t4");

        // Asynchronous reset three bits into an operation.
        wait_idle();
        a_in  = 8'h5A;
        b_in  = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_res", 32'(result), 32'd0);
        check("t5_ga", 32'(gate_a), 32'd0);
        check("t5_gb", 32'(gate_b), 32'd0);
        exp_result = '0;
        exp_zero   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(8'hC3, 8'h81, -1, "t5");

        for (int c = 0; c < 5; c++) begin
            step();
            check("t6_res", 32'(result), 32'(exp_result));
            check("t6_zero", 32'(zero), 32'(exp_zero));
            check("t6_done", 32'(done), 32'd0);
            check("t6_ga", 32'(gate_a), 32'd0);
            check("t6_gb", 32'(gate_b), 32'd0);
        end

        for (int r = 0; r < 20; r++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = (r % 4 == 0) ? ~ra : WIDTH'($urandom);
            run_op(ra, rb, (r % 3 == 0) ? int'($urandom_range(0, WIDTH - 2)) : -1, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
